// File: rtl/fpu_op_sequencer.sv
// Single-issue floating-point instruction sequencer: resolves the rounding mode, reads operands,
// runs the FPU with a bounded wait, writes results back and keeps the sticky exception flags.
module fpu_op_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    // Handshake: a request is taken on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE; resp_valid is a one-cycle pulse in WB, qualified by resp_err.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_load_data,
    input  logic [2:0]  csr_frm,
    input  logic        fflags_clr,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        rf_wen,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_w_data,
    output logic        fpu_start,
    output logic [6:0]  fpu_funct7,
    output logic [2:0]  fpu_frm,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    input  logic [31:0] fpu_out,
    input  logic [4:0]  fpu_flags,
    input  logic        fpu_ready,
    output logic [4:0]  fflags,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [1:0] OP_ARITH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [6:0]  funct7_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic [2:0]  frm_q;
    logic        err_q;
    logic [31:0] res_q;
    logic [4:0]  flg_q;
    logic [31:0] op_a_q, op_b_q;
    logic [7:0]  cnt_q;
    logic [4:0]  fflags_q;

    logic        accept;
    logic        rm_ok;
    logic [2:0]  frm_res;
    logic        wb_arith_ok;

    assign accept = req_valid && req_ready;

    // Dynamic mode (111) defers to the CSR, which must itself hold a defined mode.
    always_comb begin
        rm_ok   = 1'b0;
        frm_res = req_rm;
        if (req_rm == 3'b111) begin
            frm_res = csr_frm;
            rm_ok   = (csr_frm <= 3'b100);
        end else begin
            rm_ok   = (req_rm <= 3'b100);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        fpu_start   = 1'b0;
        rf_wen      = 1'b0;
        rf_w_data   = 32'd0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        resp_data   = 32'd0;
        wb_arith_ok = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_ARITH: state_nxt = rm_ok ? S_READ : S_WB;
                        OP_LOAD:  state_nxt = S_WB;
                        OP_STORE: state_nxt = S_READ;
                        default:  state_nxt = S_WB;
                    endcase
                end
            end
            S_READ: begin
                state_nxt = (op_q == OP_STORE) ? S_WB : S_EXEC;
            end
            S_EXEC: begin
                fpu_start = (cnt_q == 8'd0);
                if (fpu_ready || cnt_q == LAST_CNT) state_nxt = S_WB;
            end
            S_WB: begin
                state_nxt   = S_IDLE;
                resp_valid  = 1'b1;
                resp_err    = err_q;
                rf_wen      = !err_q && (op_q == OP_ARITH || op_q == OP_LOAD);
                rf_w_data   = rf_wen ? res_q : 32'd0;
                resp_data   = (op_q == OP_STORE && !err_q) ? op_b_q : 32'd0;
                wb_arith_ok = !err_q && (op_q == OP_ARITH);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_q     <= OP_ARITH;
            funct7_q <= 7'd0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            frm_q    <= 3'd0;
            err_q    <= 1'b0;
            res_q    <= 32'd0;
            flg_q    <= 5'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            cnt_q    <= 8'd0;
        end else begin
            if (accept) begin
                op_q     <= req_op;
                funct7_q <= req_funct7;
                rs1_q    <= req_rs1;
                rs2_q    <= req_rs2;
                rd_q     <= req_rd;
                frm_q    <= frm_res;
                err_q    <= (req_op == OP_RSVD) || (req_op == OP_ARITH && !rm_ok);
                cnt_q    <= 8'd0;
                if (req_op == OP_LOAD) res_q <= req_load_data;
            end
            if (state == S_READ) begin
                op_a_q <= rf_rs1_data;
                op_b_q <= rf_rs2_data;
            end
            if (state == S_EXEC) begin
                cnt_q <= cnt_q + 8'd1;
                if (fpu_ready) begin
                    res_q <= fpu_out;
                    flg_q <= fpu_flags;
                end else if (cnt_q == LAST_CNT) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // A clear landing on an arith writeback keeps only that op's flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)          fflags_q <= 5'd0;
        else if (fflags_clr) fflags_q <= wb_arith_ok ? flg_q : 5'd0;
        else if (wb_arith_ok) fflags_q <= fflags_q | flg_q;
    end

    assign rf_rs1     = rs1_q;
    assign rf_rs2     = rs2_q;
    assign rf_rd      = rd_q;
    assign fpu_funct7 = funct7_q;
    assign fpu_frm    = frm_q;
    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign fflags     = fflags_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: transaction-level model predicts each cycle's outputs from the
// op type, rounding mode and FPU latency; directed cases first, then randomized traffic.
module tb_fpu_op_sequencer;

    localparam int TO = 4;

    logic        clk, n_rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rs1, req_rs2, req_rd;
    logic [2:0]  req_rm;
    logic [31:0] req_load_data;
    logic [2:0]  csr_frm;
    logic        fflags_clr;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_w_data;
    logic        fpu_start;
    logic [6:0]  fpu_funct7;
    logic [2:0]  fpu_frm;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic [31:0] fpu_out;
    logic [4:0]  fpu_flags;
    logic        fpu_ready;
    logic [4:0]  fflags;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [1:0]  dbg_state;

    logic [31:0] rf_mem [32];
    assign rf_rs1_data = rf_mem[rf_rs1];
    assign rf_rs2_data = rf_mem[rf_rs2];

    fpu_op_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_funct7(req_funct7), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_rm(req_rm), .req_load_data(req_load_data), .csr_frm(csr_frm),
        .fflags_clr(fflags_clr), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
        .fpu_start(fpu_start), .fpu_funct7(fpu_funct7), .fpu_frm(fpu_frm),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_out(fpu_out),
        .fpu_flags(fpu_flags), .fpu_ready(fpu_ready), .fflags(fflags),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [4:0] m_fflags = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic noise_inputs();
        req_funct7    = 7'($urandom);
        req_rs1       = 5'($urandom);
        req_rs2       = 5'($urandom);
        req_rd        = 5'($urandom);
        req_rm        = 3'($urandom);
        req_op        = 2'($urandom);
        req_load_data = $urandom;
        csr_frm       = 3'($urandom);
        fpu_out       = $urandom;
        fpu_flags     = 5'($urandom);
    endtask

    task automatic idle_outputs_check(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_rf_wen"}, rf_wen, 0);
        chk({tag, "_fpu_start"}, fpu_start, 0);
        chk({tag, "_fflags"}, fflags, m_fflags);
    endtask

    task automatic reset_checks();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_state", dbg_state, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_w_data", rf_w_data, 0);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_fpu_funct7", fpu_funct7, 0);
        chk("rst_fpu_frm", fpu_frm, 0);
        chk("rst_fpu_op_a", fpu_op_a, 0);
        chk("rst_fpu_op_b", fpu_op_b, 0);
        chk("rst_sel", {rf_rs1, rf_rs2}, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_resp", {resp_valid, resp_err}, 0);
        chk("rst_resp_data", resp_data, 0);
    endtask

    // Idle cycles with no request; a random clear may be applied.
    task automatic idle_cycles(input int cnt, input bit rand_clr);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            idle_outputs_check("idle");
            req_valid  = 1'b0;
            noise_inputs();
            fpu_ready  = 1'($urandom);
            fflags_clr = rand_clr ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (fflags_clr) m_fflags = 5'd0;
        end
    endtask

    // One transaction: cycle 0 is the accept cycle; k<0 means the FPU never answers.
    task automatic run_txn(input logic [1:0] op, input logic [2:0] rm, input logic [2:0] csr,
                           input int k, input int clr_cyc, input logic [4:0] flg,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] ldata);
        bit          rm_legal, err, arith_run, exp_wen, rdy, wb_ok;
        int          wb;
        logic [2:0]  frm;
        logic [31:0] exp_a, exp_b, res, wdata;

        rm_legal  = (rm <= 3'd4) || (rm == 3'd7 && csr <= 3'd4);
        frm       = (rm == 3'd7) ? csr : rm;
        err       = 1'b0;
        case (op)
            2'b00: begin
                if (!rm_legal)   begin err = 1'b1; wb = 1; end
                else if (k < 0)  begin err = 1'b1; wb = 2 + TO; end
                else             wb = 3 + k;
            end
            2'b01:   wb = 1;
            2'b10:   wb = 2;
            default: begin err = 1'b1; wb = 1; end
        endcase
        arith_run = (op == 2'b00) && rm_legal;
        exp_a     = rf_mem[rs1];
        exp_b     = rf_mem[rs2];
        res       = $urandom;
        wdata     = (op == 2'b01) ? ldata : res;

        @(negedge clk);
        idle_outputs_check("c0");
        req_valid     = 1'b1;
        req_op        = op;
        req_rm        = rm;
        csr_frm       = csr;
        req_funct7    = f7;
        req_rd        = rd;
        req_rs1       = rs1;
        req_rs2       = rs2;
        req_load_data = ldata;
        fpu_ready     = 1'($urandom);
        fpu_out       = $urandom;
        fpu_flags     = 5'($urandom);
        fflags_clr    = (clr_cyc == 0);
        if (fflags_clr) m_fflags = 5'd0;

        for (int n = 1; n <= wb; n++) begin
            @(negedge clk);
            exp_wen = (n == wb) && !err && (op == 2'b00 || op == 2'b01);
            chk("req_ready", req_ready, 0);
            chk("resp_valid", resp_valid, n == wb);
            chk("resp_err", resp_err, (n == wb) && err);
            chk("rf_wen", rf_wen, exp_wen);
            if (exp_wen) begin
                chk("rf_rd", rf_rd, rd);
                chk("rf_w_data", rf_w_data, wdata);
            end
            chk("resp_data", resp_data, (n == wb && op == 2'b10) ? exp_b : 32'd0);
            chk("fpu_start", fpu_start, arith_run && n == 2);
            if (arith_run && n >= 2 && n < wb) begin
                chk("fpu_op_a", fpu_op_a, exp_a);
                chk("fpu_op_b", fpu_op_b, exp_b);
                chk("fpu_funct7", fpu_funct7, f7);
                chk("fpu_frm", fpu_frm, frm);
            end
            if (n == 1 && op == 2'b10) chk("rf_rs2", rf_rs2, rs2);
            chk("fflags", fflags, m_fflags);
            if (exp_wen) rf_mem[rd] = wdata;

            req_valid = 1'($urandom);
            noise_inputs();
            if (arith_run && n >= 2 && (k < 0 ? n <= 1 + TO : n <= 2 + k)) begin
                rdy = (k >= 0) && (n == 2 + k);
                fpu_ready = rdy;
                if (rdy) begin
                    fpu_out   = res;
                    fpu_flags = flg;
                end
            end else begin
                fpu_ready = 1'($urandom);
            end
            fflags_clr = (clr_cyc == n);
            wb_ok = (n == wb) && (op == 2'b00) && !err;
            if (fflags_clr)  m_fflags = wb_ok ? flg : 5'd0;
            else if (wb_ok)  m_fflags = m_fflags | flg;
        end
    endtask

    initial begin
        int op_sel, k, clr, rm_sel;
        logic [1:0] op;
        logic [2:0] rm;

        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        n_rst = 1'b0;
        req_valid = 1'b0;
        fflags_clr = 1'b0;
        fpu_ready = 1'b0;
        noise_inputs();
        repeat (3) @(negedge clk);
        reset_checks();
        n_rst = 1'b1;

        // Directed cases
        run_txn(2'b01, 3'd0, 3'd0, 0, -1, 5'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h3F800000);
        run_txn(2'b00, 3'd0, 3'd0, 3, -1, 5'b00001, 7'h10, 5'd7, 5'd1, 5'd2, 32'd0);
        idle_cycles(1, 1'b0);
        chk("pin_fflags_nx", fflags, 5'b00001);
        run_txn(2'b00, 3'b111, 3'b010, 1, -1, 5'd0, 7'h04, 5'd8, 5'd3, 5'd4, 32'd0);
        run_txn(2'b00, 3'b111, 3'b101, 1, -1, 5'b11111, 7'h04, 5'd8, 5'd3, 5'd4, 32'd0);
        run_txn(2'b01, 3'd0, 3'd0, 0, -1, 5'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'h40490FDB);
        run_txn(2'b10, 3'd0, 3'd0, 0, -1, 5'd0, 7'h00, 5'd0, 5'd1, 5'd9, 32'd0);
        run_txn(2'b00, 3'd1, 3'd0, -1, -1, 5'b01000, 7'h08, 5'd10, 5'd5, 5'd6, 32'd0);
        run_txn(2'b11, 3'd0, 3'd0, 0, -1, 5'd0, 7'h00, 5'd11, 5'd0, 5'd0, 32'd0);
        idle_cycles(1, 1'b0);
        chk("pin_fflags_after_timeout", fflags, 5'b00001);
        run_txn(2'b00, 3'd2, 3'd0, 0, 3, 5'b10000, 7'h01, 5'd12, 5'd1, 5'd2, 32'd0);
        idle_cycles(1, 1'b0);
        chk("pin_fflags_nv", fflags, 5'b10000);
        run_txn(2'b00, 3'd3, 3'd0, 2, 5, 5'b00100, 7'h02, 5'd13, 5'd3, 5'd4, 32'd0);
        idle_cycles(1, 1'b0);
        chk("pin_fflags_clr_wb", fflags, 5'b00100);

        // Reset while in EXEC: nothing written, flags cleared
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_rm = 3'd0; req_rd = 5'd14;
        fflags_clr = 1'b0; fpu_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
            fpu_ready = 1'b0;
        end
        chk("exec_state_busy", req_ready, 0);
        n_rst = 1'b0;
        #1;
        m_fflags = 5'd0;
        reset_checks();
        @(negedge clk);
        n_rst = 1'b1;

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            op_sel = $urandom_range(0, 9);
            op = (op_sel < 5) ? 2'b00 : (op_sel < 7) ? 2'b01 : (op_sel < 9) ? 2'b10 : 2'b11;
            rm_sel = $urandom_range(0, 9);
            rm = (rm_sel < 7) ? 3'($urandom_range(0, 4)) : (rm_sel < 9) ? 3'b111 : 3'($urandom_range(5, 6));
            k = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TO - 1);
            clr = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
            run_txn(op, rm, 3'($urandom), k, clr, 5'($urandom), 7'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'b1);
        end
        idle_cycles(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Sequences one floating-point instruction at a time through the FP register file and the FPU datapath. Accepts an arithmetic, load or store request from the issue stage and drives the register-file read ports. For arithmetic ops it starts the FPU, waits for its ready, and writes the result back. It resolves the rounding mode and maintains the sticky exception flags (NV, DZ, OF, UF, NX).

## Interface
Parameters:
- TIMEOUT, 64: max EXEC cycles waiting for fpu_ready before aborting with error; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  2  00 arith, 01 load, 10 store, 11 reserved.
- req_funct7  in  7  FPU operation select.
- req_rs1, req_rs2, req_rd  in  5 each  register indices.
- req_rm  in  3  instruction rounding mode; 111 = dynamic.
- req_load_data  in  32  memory data for load.
- csr_frm  in  3  dynamic rounding mode from CSR.
- fflags_clr  in  1  clear sticky flags.
- rf_rs1, rf_rs2  out  5 each  register-file read selects.
- rf_rs1_data, rf_rs2_data  in  32 each  combinational read data.
- rf_wen  out  1  write enable.
- rf_rd  out  5  write index.
- rf_w_data  out  32  write data.
- fpu_start  out  1  one-cycle start pulse.
- fpu_funct7  out  7  operation to FPU.
- fpu_frm  out  3  resolved rounding mode.
- fpu_op_a, fpu_op_b  out  32 each  operands, held through EXEC.
- fpu_out  in  32  FPU result.
- fpu_flags  in  5  FPU exception flags.
- fpu_ready  in  1  result valid.
- fflags  out  5  sticky flags {NV,DZ,OF,UF,NX}.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid.
- resp_data  out  32  store data (rs2) on store completion, else 0.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- Request fields are latched on accept (req_valid && req_ready).
- IDLE transitions on accept:
  - arith/store -> READ.
  - load -> WB.
  - reserved op -> WB with error.
- Rounding-mode resolution at accept:
  - rm in {000..100} is used directly.
  - rm=111 uses csr_frm.
  - Illegal if rm in {101,110}, or rm=111 with csr_frm in {101,110,111}.
  - An illegal arith op goes directly to WB with error, skipping READ and EXEC.
- READ:
  - rf_rs1/rf_rs2 driven from latched indices.
  - Operands captured into fpu_op_a/b at end of cycle.
  - Store -> WB; arith -> EXEC.
- EXEC:
  - fpu_start=1 in the first EXEC cycle only.
  - fpu_funct7, fpu_frm and operands are stable for the whole state.
  - 8-bit wait counter counts EXEC cycles.
  - fpu_ready=1 captures fpu_out and fpu_flags and moves to WB.
  - If counter reaches TIMEOUT without fpu_ready, the op goes to WB with error.
- WB (one cycle, resp_valid=1, then IDLE):
  - arith, no error: rf_wen=1, rf_rd=latched rd, rf_w_data=captured result; fflags |= captured flags.
  - load: rf_wen=1, rf_w_data=latched load data; fflags unchanged.
  - store: rf_wen=0, resp_data=captured rs2.
  - error: rf_wen=0, resp_err=1, fflags unchanged.
- fflags_clr is honoured in any state. If it coincides with an arith WB, fflags takes the new flags only; clear wins over the old bits.
- Reset values:
  - State IDLE; req_ready=1.
  - All other outputs 0: rf_wen, fpu_start, resp_valid, resp_err, resp_data, fflags, operands, selects.
- Reset asserted mid-op aborts it: no write, no response, flags cleared.

## Timing
- Load: accept at edge 0; WB in cycle 1; rf_wen and resp_valid at cycle 1. Latency 1.
- Store: READ in cycle 1, WB in cycle 2. Latency 2.
- Arith: READ in cycle 1; EXEC from cycle 2, fpu_start in cycle 2.
  - fpu_ready sampled high in EXEC cycle 2+k (k ≥ 0) -> WB in cycle 3+k.
  - fpu_ready is ignored in cycles outside EXEC.
- Timeout: WB with error in cycle 2+TIMEOUT.
- Illegal rm or reserved op: WB with error in cycle 1.
- Throughput: req_ready is low from cycle 1 through WB and high again the cycle after WB. Back-to-back accept is possible on that cycle.

## Test plan
- Reset then load, rd=5, data 0x3F800000 -> cycle 1: rf_wen=1, rf_rd=5, rf_w_data=0x3F800000, resp_valid=1, resp_err=0, fflags=0.
- Arith, rm=000, FPU ready 3 cycles after start with fpu_flags=00001 -> fpu_start in cycle 2 only; WB in cycle 6; rf_w_data=fpu_out; fflags=00001.
- Arith, rm=111 with csr_frm=010 -> fpu_frm=010. Repeat with csr_frm=101 -> resp_err in cycle 1, no fpu_start, no write.
- Store, rs2 holding 0x40490FDB -> resp_valid and resp_data=0x40490FDB in cycle 2; rf_wen stays 0.
- TIMEOUT=4, fpu_ready never asserted -> resp_err in cycle 6, rf_wen=0, fflags unchanged; next request accepted in cycle 7.
- fflags=10000 with fflags_clr asserted in the WB cycle of an op raising 00100 -> fflags=00100. Separately, n_rst asserted during EXEC -> all outputs 0, state IDLE, no rf write.
